// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns and lane-replicates stores, extends loads, and bounds
// every memory access with a timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        store_size,
  input  logic [1:0]        load_size,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_out,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic              bus_err,
  load_store_unit_if.master mem
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             we_q, we_d;
  logic             bus_err_q, bus_err_d;

  logic [1:0]  req_size;
  logic        req_any;
  logic        req_mis;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_funct3;

  assign unused_funct3 = ^funct3[2:1];
  assign req_any       = req_load | req_store;

  // Effective size of the incoming access; a store wins over a simultaneous load.
  always_comb begin
    req_size = SZ_W;
    if (req_store) begin
      case (store_size)
        2'b00:   req_size = SZ_B;
        2'b01:   req_size = SZ_H;
        default: req_size = SZ_W;
      endcase
    end else begin
      case (load_size)
        2'b00:   req_size = SZ_B;
        2'b01:   req_size = SZ_H;
        2'b10:   req_size = SZ_W;
        default: req_size = funct3[0] ? SZ_H : SZ_B;
      endcase
    end
  end

  assign req_mis = ((req_size == SZ_H) && addr[0]) ||
                   ((req_size == SZ_W) && (addr[1:0] != 2'b00));
  assign accept  = (state_q == S_IDLE) && req_any && !req_mis;

  assign ld_byte = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    we_d          = we_q;
    bus_err_d     = 1'b0;
    stall         = 1'b0;
    done          = 1'b0;
    misaligned    = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_be    = '0;

    case (state_q)
      S_IDLE: begin
        misaligned = req_any && req_mis;
        if (accept) begin
          stall   = 1'b1;
          state_d = S_REQ;
          cnt_d   = '0;
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = req_size;
          uns_d   = !req_store && (load_size == 2'b11);
          we_d    = req_store;
        end
      end
      S_REQ: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_we   = we_q;
        mem.mem_addr = {addr_q[31:2], 2'b00};
        mem.mem_be   = 4'b1111;
        if (we_q) begin
          case (size_q)
            SZ_B: begin
              mem.mem_be    = 4'b0001 << addr_q[1:0];
              mem.mem_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
              mem.mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
              mem.mem_wdata = {2{wdata_q[15:0]}};
            end
            default: mem.mem_wdata = wdata_q;
          endcase
        end
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the last allowed cycle takes priority over the timeout.
        if (mem.mem_ack) begin
          state_d = S_RESP;
          if (!we_q) begin
            case (size_q)
              SZ_B:    rdata_d = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
              SZ_H:    rdata_d = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
              default: rdata_d = mem.mem_rdata;
            endcase
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end
      end
      S_RESP: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_out = rdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: the driver pushes reference-model expectations, a negedge
// monitor pops and compares them as completion/misaligned/bus_err events appear.
module tb_load_store_unit;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_load, req_store;
  logic [1:0]  store_size, load_size;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_out;
  logic        stall, done, misaligned, bus_err;

  always #5 clk = ~clk;

  load_store_unit_if mem();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_load   (req_load),
    .req_store  (req_store),
    .store_size (store_size),
    .load_size  (load_size),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata_out  (rdata_out),
    .stall      (stall),
    .done       (done),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem        (mem)
  );

  typedef struct {
    logic [2:0]  kind;   // {bus_err, misaligned, done}
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  bit          req_seen = 0;
  bit          bus_chk = 0;
  bit          end_req = 0;
  bit          end_done = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outcome of one access from size/alignment rules and byte arithmetic.
  function automatic exp_t model(input bit st, input logic [1:0] ssz, input logic [1:0] lsz,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int ack_at, input logic [31:0] prev);
    exp_t            e;
    int              nbytes;
    int              lane;
    bit              sgn;
    bit              completes;
    longint unsigned m;
    logic [31:0]     v;
    sgn = 1'b0;
    if (st) nbytes = (ssz == 2'd0) ? 1 : (ssz == 2'd1) ? 2 : 4;
    else begin
      case (lsz)
        2'd0:    begin nbytes = 1; sgn = 1'b1; end
        2'd1:    begin nbytes = 2; sgn = 1'b1; end
        2'd2:    nbytes = 4;
        default: nbytes = f3[0] ? 2 : 1;
      endcase
    end
    lane    = int'(a[1:0]);
    e.req   = (lane % nbytes) == 0;
    e.we    = st;
    e.addr  = a - 32'(lane);
    e.rdata = prev;
    e.be    = 4'h0;
    e.wdata = 32'h0;
    if (!e.req) begin
      e.kind  = 3'b010;
      e.stall = 0;
      return e;
    end
    e.be    = st ? 4'(((1 << nbytes) - 1) << lane) : 4'hF;
    e.wdata = (nbytes == 1) ? 32'(wd[7:0]) * 32'h01010101 :
              (nbytes == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
    completes = (ack_at >= 1) && (ack_at <= int'(TO));
    e.stall   = 1 + (completes ? ack_at : int'(TO));
    e.kind    = completes ? 3'b001 : 3'b100;
    if (completes && !st) begin
      m = (64'd1 << (8 * nbytes)) - 64'd1;
      v = 32'((64'(rd) >> (8 * lane)) & m);
      if (sgn && (((v >> (8 * nbytes - 1)) & 32'd1) != 0)) v = v | ~32'(m);
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic txn(input bit st, input bit ld, input logic [1:0] ssz, input logic [1:0] lsz,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int ack_at);
    exp_t e;
    e = model(st, ssz, lsz, f3, a, wd, rd, ack_at, model_rdata);
    q.push_back(e);
    @(posedge clk); #1;
    req_store = st; req_load = ld; store_size = ssz; load_size = lsz;
    funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_store = 1'b0; req_load = 1'b0;
    if (e.req) begin
      for (int k = 1; k <= int'(TO); k++) begin
        mem.mem_ack   = (k == ack_at);
        mem.mem_rdata = (k == ack_at) ? rd : $urandom;
        @(posedge clk); #1;
        if (k == ack_at) break;
      end
      mem.mem_ack = 1'b0;
    end
    model_rdata = e.rdata;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: reset-state checks, bus content on the first REQ cycle, and event scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", 32'({mem.mem_req, mem.mem_we, mem.mem_be, stall, done, misaligned, bus_err}), 32'h0);
      chk("rst_mem_addr", mem.mem_addr, 32'h0);
      chk("rst_mem_wdata", mem.mem_wdata, 32'h0);
      chk("rst_rdata_out", rdata_out, 32'h0);
      q.delete();
      stall_cnt = 0; req_seen = 1'b0; bus_chk = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (mem.mem_req) begin
        req_seen = 1'b1;
        if (!bus_chk) begin
          bus_chk = 1'b1;
          if (q.size() == 0) chk("unexpected_mem_req", 32'(q.size()), 32'd1);
          else begin
            chk("mem_be", 32'(mem.mem_be), 32'(q[0].be));
            chk("mem_addr", mem.mem_addr, q[0].addr);
            chk("mem_we", 32'(mem.mem_we), 32'(q[0].we));
            if (q[0].we) chk("mem_wdata", mem.mem_wdata, q[0].wdata);
          end
        end
      end
      if (done || misaligned || bus_err) begin
        if (q.size() == 0) chk("unexpected_event", 32'({bus_err, misaligned, done}), 32'h0);
        else begin
          mon_e = q.pop_front();
          chk("event_kind", 32'({bus_err, misaligned, done}), 32'(mon_e.kind));
          chk("rdata_out", rdata_out, mon_e.rdata);
          chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
          chk("mem_req_seen", 32'(req_seen), 32'(mon_e.req));
        end
        stall_cnt = 0; req_seen = 1'b0; bus_chk = 1'b0;
      end
      if (end_req && !end_done) begin
        end_done = 1'b1;
        chk("queue_drained", 32'(q.size()), 32'h0);
      end
    end
  end

  initial begin
    exp_t e;
    int   r;
    int   ack_at;
    bit   st;
    rst_n = 1'b0;
    req_load = 1'b0; req_store = 1'b0; store_size = 2'b00; load_size = 2'b00;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem.mem_ack = 1'b0; mem.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1, 0, 2'b10, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    txn(1, 0, 2'b00, 2'b00, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
    txn(1, 1, 2'b01, 2'b10, 3'b001, 32'h106, 32'h1234CAFE, 32'h0, 2);
    txn(0, 1, 2'b00, 2'b00, 3'b000, 32'h200, 32'h0, 32'h80F17F82, 1);
    txn(0, 1, 2'b00, 2'b11, 3'b100, 32'h201, 32'h0, 32'h80F17F82, 1);
    txn(0, 1, 2'b00, 2'b01, 3'b001, 32'h202, 32'h0, 32'h80F17F82, 1);
    txn(0, 1, 2'b00, 2'b11, 3'b101, 32'h202, 32'h0, 32'h80F17F82, 1);
    txn(0, 1, 2'b00, 2'b10, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    txn(1, 0, 2'b01, 2'b00, 3'b001, 32'h101, 32'h5555AAAA, 32'h0, 1);
    txn(0, 1, 2'b00, 2'b10, 3'b010, 32'h204, 32'h0, 32'h11111111, 0);
    txn(0, 1, 2'b00, 2'b10, 3'b010, 32'h208, 32'h0, 32'h12345678, int'(TO));

    // Reset in the second REQ cycle, then a stray ack once reset is released.
    e = model(0, 2'b00, 2'b10, 3'b010, 32'h300, 32'h0, 32'h0, 0, model_rdata);
    q.push_back(e);
    @(posedge clk); #1;
    req_load = 1'b1; load_size = 2'b10; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    req_load = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 mem.mem_ack = 1'b0;
    model_rdata = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 80; i++) begin
      r      = int'($urandom_range(0, 9));
      ack_at = (r == 0) ? 0 : ((r - 1) % int'(TO)) + 1;
      st     = 1'($urandom);
      txn(st, st ? 1'($urandom) : 1'b1, 2'($urandom), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom, ack_at);
    end

    end_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of REQ-state cycles allowed without mem_ack.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_load  in  1  decoded load request (IL-type).
REQ-006 req_store  in  1  decoded store request (d_wr_en).
REQ-007 store_size  in  2  00 sb, 01 sh, 10 sw; 11 treated as sw.
REQ-008 load_size  in  2  00 lb, 01 lh, 10 lw, 11 unsigned (lbu/lhu).
REQ-009 funct3  in  3  instruction funct3; bit 0 selects lhu (1) or lbu (0) when load_size=11.
REQ-010 addr  in  32  byte address from the ALU result.
REQ-011 wdata  in  32  rs2 store data.
REQ-012 rdata_out  out  32  extended load result to the writeback mux (dRdata).
REQ-013 stall  out  1  freezes PC and pipeline while high.
REQ-014 done  out  1  one-cycle pulse on access completion.
REQ-015 misaligned  out  1  one-cycle pulse on a rejected misaligned access.
REQ-016 bus_err  out  1  one-cycle pulse on timeout.
REQ-017 mem_req / mem_we  out  1 each  memory request and write enable.
REQ-018 mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-019 mem_wdata  out  32  lane-replicated store data.
REQ-020 mem_be  out  4  byte enables; bit n = byte lane n.
REQ-021 mem_rdata  in  32  read word, sampled only with mem_ack.
REQ-022 mem_ack  in  1  memory completion, valid only in REQ.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, REQ, RESP.
REQ-024 Request acceptance: IDLE and (req_load or req_store) and aligned. On that edge capture addr, wdata, sizes, funct3 and op, then move to REQ.
REQ-025 req_store and req_load high together SHALL be handled as a store only.
REQ-026 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=00. The unit SHALL pulse misaligned combinationally in that IDLE cycle, issue no memory access, keep stall=0, and stay in IDLE.
REQ-027 stall SHALL be 1 combinationally in an IDLE cycle that accepts a request, and in every REQ cycle; it SHALL be 0 in RESP and otherwise.
REQ-028 In REQ, mem_req SHALL be 1 and mem_we SHALL equal the captured op (1=store); mem_req SHALL be 0 in all other states.
REQ-029 Store byte lanes:
  - sb: mem_be=0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - sh: mem_be=0011 if addr[1]=0, else 1100; mem_wdata={2{wdata[15:0]}}.
  - sw: mem_be=1111, mem_wdata=wdata.
REQ-030 For loads, mem_be SHALL be 1111.
REQ-031 mem_ack=1 in REQ SHALL move the FSM to RESP on that edge. For a load, the same edge SHALL update rdata_out from mem_rdata using the captured addr[1:0] and size:
  - lb: sign-extended byte; lh: sign-extended half (selected by addr[1]); lw: full word.
  - load_size=11: lbu (funct3[0]=0) or lhu (funct3[0]=1), zero-extended.
REQ-032 Stores SHALL leave rdata_out unchanged; rdata_out SHALL hold its value until the next completed load.
REQ-033 In RESP, done SHALL be 1 for exactly one cycle; the next state SHALL always be IDLE, and no request is accepted in RESP.
REQ-034 Timeout counter:
  - Counts REQ cycles; clears on entry to REQ.
  - If TIMEOUT_CYCLES cycles pass in REQ without mem_ack, pulse bus_err for one cycle, return to IDLE, assert no done, and leave rdata_out unchanged.
  - mem_ack in the final timeout cycle SHALL win: completion, no bus_err.
REQ-035 Minimum latency SHALL be 3 cycles (accept, REQ with immediate ack, RESP), with stall high for 2 cycles.

Reset
REQ-036 rst_n=0 SHALL immediately force state=IDLE, the counter and all captured registers to 0, and rdata_out=0. All outputs (mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall, done, misaligned, bus_err) SHALL be 0.
REQ-037 Reset during REQ SHALL drop mem_req asynchronously; a mem_ack that arrives after reset SHALL be ignored.

Verification
REQ-038 sw addr=0x100, wdata=0xDEADBEEF, ack on the first REQ cycle -> mem_be=1111, mem_addr=0x100, stall high 2 cycles, done pulse in cycle 3.
REQ-039 sb addr=0x103, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-040 Loads of mem_rdata=0x80F1_7F82:
  - lb addr=0x200 -> rdata_out=0xFFFFFF82.
  - lbu addr=0x201 -> 0x0000007F.
  - lh addr=0x202 -> 0xFFFF80F1.
  - lhu addr=0x202 -> 0x000080F1.
REQ-041 lw addr=0x102 -> misaligned pulse, mem_req never asserted, stall=0; sh addr=0x101 -> same result.
REQ-042 Load with mem_ack held low, TIMEOUT_CYCLES=4 -> 4 REQ cycles, bus_err pulse, return to IDLE, no done, rdata_out unchanged; repeat with ack in cycle 4 -> done, no bus_err.
REQ-043 rst_n pulled low in the 2nd REQ cycle, then mem_ack=1 after release -> mem_req=0 immediately, state IDLE, no done, rdata_out=0.
